wb_commit: RTL and testbench

- Dual-lane writeback stage that drives both write ports of the register file.
- Merges three sources: lane A retirements, lane B retirements, and out-of-band load returns from the data memory interface.
- Lanes A and B never stall. Load returns are buffered in a small FIFO and drained into whichever write port is idle.
- Exports a per-register busy mask so the issue stage can hold instructions that depend on a queued load.

---
 rtl/wb_commit_if.sv | 46 ++++
 rtl/wb_commit.sv | 159 +++++++++++++++
 tb/tb_wb_commit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_if.sv
// Writeback bus: lane A/B retirements and load returns in, both regfile write ports out.
interface wb_commit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                     A_valid_i;
    logic [4:0]               A_rd_addr_i;
    logic [XLEN-1:0]          A_rd_data_i;
    logic                     A_rd_write_i;
    logic                     B_valid_i;
    logic [4:0]               B_rd_addr_i;
    logic [XLEN-1:0]          B_rd_data_i;
    logic                     B_rd_write_i;
    logic                     ld_valid_i;
    logic [4:0]               ld_rd_addr_i;
    logic [XLEN-1:0]          ld_data_i;
    logic                     ld_ready_o;
    logic [4:0]               A_rd_addr_o;
    logic [XLEN-1:0]          A_rd_data_o;
    logic                     A_rd_write_o;
    logic [4:0]               B_rd_addr_o;
    logic [XLEN-1:0]          B_rd_data_o;
    logic                     B_rd_write_o;
    logic [31:0]              ld_busy_o;
    logic [$clog2(DEPTH):0]   ld_count_o;

    modport master (
        output A_valid_i, A_rd_addr_i, A_rd_data_i, A_rd_write_i,
        output B_valid_i, B_rd_addr_i, B_rd_data_i, B_rd_write_i,
        output ld_valid_i, ld_rd_addr_i, ld_data_i,
        input  ld_ready_o,
        input  A_rd_addr_o, A_rd_data_o, A_rd_write_o,
        input  B_rd_addr_o, B_rd_data_o, B_rd_write_o,
        input  ld_busy_o, ld_count_o
    );

    modport slave (
        input  A_valid_i, A_rd_addr_i, A_rd_data_i, A_rd_write_i,
        input  B_valid_i, B_rd_addr_i, B_rd_data_i, B_rd_write_i,
        input  ld_valid_i, ld_rd_addr_i, ld_data_i,
        output ld_ready_o,
        output A_rd_addr_o, A_rd_data_o, A_rd_write_o,
        output B_rd_addr_o, B_rd_data_o, B_rd_write_o,
        output ld_busy_o, ld_count_o
    );
endinterface

// File: rtl/wb_commit.sv
// Dual-lane writeback: lanes A/B own their ports when writing; queued load returns
// fill idle ports in order, with a per-register busy mask for queued loads.
module wb_commit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic        clock_i,
    input  logic        reset_i,
    wb_commit_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Holds up to DEPTH queued plus two loads sitting in the drain registers.
    localparam int BW = $clog2(DEPTH + 3);

    logic [4:0]      fifo_addr [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, head_b;
    logic [CW-1:0]   count;
    logic [BW-1:0]   busy_cnt [32];
    logic            drain_a, drain_b;
    logic [4:0]      drain_a_addr, drain_b_addr;

    logic            ready, claim_a, claim_b;
    logic            sel_a_vld, sel_a_ld, sel_b_vld, sel_b_ld;
    logic [4:0]      sel_a_addr, sel_b_addr;
    logic [XLEN-1:0] sel_a_data, sel_b_data;
    logic [1:0]      pops;
    logic            acc, ld_keep, bypass, push, kill_a, kill_b;
    logic            wr_a, wr_b;

    assign ready          = !reset_i && (count < CW'(DEPTH));
    assign bus.ld_ready_o = ready;
    assign bus.ld_count_o = count;

    always_comb begin
        claim_a    = bus.A_valid_i & bus.A_rd_write_i & (bus.A_rd_addr_i != 5'd0);
        claim_b    = bus.B_valid_i & bus.B_rd_write_i & (bus.B_rd_addr_i != 5'd0);
        sel_a_vld  = 1'b0;
        sel_a_ld   = 1'b0;
        sel_a_addr = '0;
        sel_a_data = '0;
        sel_b_vld  = 1'b0;
        sel_b_ld   = 1'b0;
        sel_b_addr = '0;
        sel_b_data = '0;
        pops       = 2'd0;

        if (claim_a) begin
            sel_a_vld  = 1'b1;
            sel_a_addr = bus.A_rd_addr_i;
            sel_a_data = bus.A_rd_data_i;
        end else if (count != '0) begin
            sel_a_vld  = 1'b1;
            sel_a_ld   = 1'b1;
            sel_a_addr = fifo_addr[rd_ptr];
            sel_a_data = fifo_data[rd_ptr];
            pops       = 2'd1;
        end

        head_b = rd_ptr + PW'(pops);
        if (claim_b) begin
            sel_b_vld  = 1'b1;
            sel_b_addr = bus.B_rd_addr_i;
            sel_b_data = bus.B_rd_data_i;
        end else if (count > CW'(pops)) begin
            sel_b_vld  = 1'b1;
            sel_b_ld   = 1'b1;
            sel_b_addr = fifo_addr[head_b];
            sel_b_data = fifo_data[head_b];
            pops       = pops + 2'd1;
        end

        // Loads to x0 are consumed here and never reach the FIFO or the busy mask.
        acc     = bus.ld_valid_i & ready;
        ld_keep = acc & (bus.ld_rd_addr_i != 5'd0);
        bypass  = ld_keep & (count == CW'(pops)) & !(sel_a_vld & sel_b_vld);
        push    = ld_keep & !bypass;

        if (bypass) begin
            if (!sel_a_vld) begin
                sel_a_vld  = 1'b1;
                sel_a_ld   = 1'b1;
                sel_a_addr = bus.ld_rd_addr_i;
                sel_a_data = bus.ld_data_i;
            end else begin
                sel_b_vld  = 1'b1;
                sel_b_ld   = 1'b1;
                sel_b_addr = bus.ld_rd_addr_i;
                sel_b_data = bus.ld_data_i;
            end
        end

        // Port B is younger unless it carries a load and port A carries lane A.
        kill_a = 1'b0;
        kill_b = 1'b0;
        if (sel_a_vld && sel_b_vld && (sel_a_addr == sel_b_addr)) begin
            if (!sel_a_ld && sel_b_ld) kill_b = 1'b1;
            else                       kill_a = 1'b1;
        end
        wr_a = sel_a_vld & !kill_a;
        wr_b = sel_b_vld & !kill_b;
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.ld_rd_addr_i;
            fifo_data[wr_ptr] <= bus.ld_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            drain_a          <= 1'b0;
            drain_b          <= 1'b0;
            drain_a_addr     <= '0;
            drain_b_addr     <= '0;
            bus.A_rd_write_o <= 1'b0;
            bus.A_rd_addr_o  <= '0;
            bus.A_rd_data_o  <= '0;
            bus.B_rd_write_o <= 1'b0;
            bus.B_rd_addr_o  <= '0;
            bus.B_rd_data_o  <= '0;
            for (int r = 0; r < 32; r++) busy_cnt[r] <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pops);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            count  <= count + CW'(push) - CW'(pops);

            bus.A_rd_write_o <= wr_a;
            bus.A_rd_addr_o  <= wr_a ? sel_a_addr : '0;
            bus.A_rd_data_o  <= wr_a ? sel_a_data : '0;
            bus.B_rd_write_o <= wr_b;
            bus.B_rd_addr_o  <= wr_b ? sel_b_addr : '0;
            bus.B_rd_data_o  <= wr_b ? sel_b_data : '0;

            // Suppressed loads still drain so their busy count is released.
            drain_a      <= sel_a_ld;
            drain_a_addr <= sel_a_addr;
            drain_b      <= sel_b_ld;
            drain_b_addr <= sel_b_addr;

            for (int r = 0; r < 32; r++) begin
                busy_cnt[r] <= busy_cnt[r]
                             + BW'(ld_keep && (bus.ld_rd_addr_i == 5'(r)))
                             - BW'(drain_a && (drain_a_addr == 5'(r)))
                             - BW'(drain_b && (drain_b_addr == 5'(r)));
            end
        end
    end

    always_comb begin
        bus.ld_busy_o = '0;
        for (int r = 0; r < 32; r++) bus.ld_busy_o[r] = (busy_cnt[r] != '0);
    end
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: per-cycle expected port writes are queued as stimulus
// is driven and popped when the registered outputs appear.
module tb_wb_commit;
    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clock_i = ~clock_i;

    wb_commit_if #(.XLEN(32), .DEPTH(4)) bus ();
    wb_commit #(.DEPTH(4), .XLEN(32)) dut (.clock_i(clock_i), .reset_i(reset_i), .bus(bus));

    typedef struct packed {
        logic        aw;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bw;
        logic [4:0]  ba;
        logic [31:0] bd;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push_exp(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                            input logic bw, input logic [4:0] ba, input logic [31:0] bd);
        exp_t e;
        e = '{aw: aw, aa: aa, ad: ad, bw: bw, ba: ba, bd: bd};
        exp_q.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t o, e;
        @(posedge clock_i);
        #1;
        o = '{aw: bus.A_rd_write_o, aa: bus.A_rd_addr_o, ad: bus.A_rd_data_o,
              bw: bus.B_rd_write_o, ba: bus.B_rd_addr_o, bd: bus.B_rd_data_o};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: no expectation queued, observed %0h", tag, o);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 80'(o), 80'(e));
        end
    endtask

    task automatic lanes(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        bus.A_valid_i = av; bus.A_rd_write_i = av; bus.A_rd_addr_i = aa; bus.A_rd_data_i = ad;
        bus.B_valid_i = bv; bus.B_rd_write_i = bv; bus.B_rd_addr_i = ba; bus.B_rd_data_i = bd;
    endtask

    task automatic ld(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.ld_valid_i = v; bus.ld_rd_addr_i = a; bus.ld_data_i = d;
    endtask

    initial begin
        lanes(0, 0, 0, 0, 0, 0);
        ld(0, 0, 0);

        // reset state
        push_exp(0, 0, 0, 0, 0, 0);
        tick("reset_outputs");
        chk("reset_ready", 80'(bus.ld_ready_o), 80'(0));
        chk("reset_count", 80'(bus.ld_count_o), 80'(0));
        chk("reset_busy", 80'(bus.ld_busy_o), 80'(0));
        reset_i = 1'b0;
        #1;
        chk("ready_after_reset", 80'(bus.ld_ready_o), 80'(1));

        // both lanes write distinct registers
        lanes(1, 3, 32'h11, 1, 4, 32'h22);
        push_exp(1, 3, 32'h11, 1, 4, 32'h22);
        tick("lanes_ab");
        chk("lanes_count", 80'(bus.ld_count_o), 80'(0));

        // idle lanes, load bypasses onto port A
        lanes(0, 0, 0, 0, 0, 0);
        ld(1, 7, 32'hDEAD);
        push_exp(1, 7, 32'hDEAD, 0, 0, 0);
        tick("ld_bypass");
        chk("busy7_high", 80'(bus.ld_busy_o), 80'(32'h80));
        ld(0, 0, 0);
        push_exp(0, 0, 0, 0, 0, 0);
        tick("idle_after_bypass");
        chk("busy7_clear", 80'(bus.ld_busy_o), 80'(0));

        // fill FIFO while both lanes write; x5 is held back when full
        for (int c = 0; c < 5; c++) begin
            lanes(1, 5'(10 + c), 32'(c), 1, 5'(20 + c), 32'(100 + c));
            ld(1, 5'(c + 1), 32'(32'h100 + c + 1));
            chk($sformatf("fill_ready%0d", c), 80'(bus.ld_ready_o), 80'(c < 4));
            push_exp(1, 5'(10 + c), 32'(c), 1, 5'(20 + c), 32'(100 + c));
            tick($sformatf("fill_lanes%0d", c));
            chk($sformatf("fill_count%0d", c), 80'(bus.ld_count_o), 80'((c + 1 > 4) ? 4 : c + 1));
        end
        chk("full_busy", 80'(bus.ld_busy_o), 80'(32'h1E));
        lanes(0, 0, 0, 0, 0, 0);
        chk("full_ready_low", 80'(bus.ld_ready_o), 80'(0));
        push_exp(1, 1, 32'h101, 1, 2, 32'h102);
        tick("drain_x1_x2");
        chk("drain_count2", 80'(bus.ld_count_o), 80'(2));
        push_exp(1, 3, 32'h103, 1, 4, 32'h104);
        tick("drain_x3_x4");
        chk("drain_count_x5", 80'(bus.ld_count_o), 80'(1));
        ld(0, 0, 0);
        push_exp(1, 5, 32'h105, 0, 0, 0);
        tick("drain_x5");
        chk("busy_x5", 80'(bus.ld_busy_o), 80'(32'h20));
        chk("drain_count0", 80'(bus.ld_count_o), 80'(0));
        push_exp(0, 0, 0, 0, 0, 0);
        tick("drained_idle");
        chk("busy_drained", 80'(bus.ld_busy_o), 80'(0));

        // same-rd collision between lanes: B wins
        lanes(1, 9, 32'd1, 1, 9, 32'd2);
        push_exp(0, 0, 0, 1, 9, 32'd2);
        tick("waw_lanes");

        // lane A owns port A, bypassed load lands on port B
        lanes(1, 6, 32'd5, 0, 0, 0);
        ld(1, 8, 32'h77);
        push_exp(1, 6, 32'd5, 1, 8, 32'h77);
        tick("bypass_port_b");
        ld(0, 0, 0);

        // lane write to x0 and valid-without-write produce nothing
        lanes(1, 0, 32'hFF, 1, 12, 32'hEE);
        bus.B_rd_write_i = 1'b0;
        push_exp(0, 0, 0, 0, 0, 0);
        tick("no_write_cases");

        // two queued loads to the same rd: younger (port B) wins, busy held until both drain
        lanes(1, 20, 32'd0, 1, 21, 32'd0);
        ld(1, 14, 32'hA1);
        push_exp(1, 20, 32'd0, 1, 21, 32'd0);
        tick("dup_q1");
        ld(1, 14, 32'hA2);
        push_exp(1, 20, 32'd0, 1, 21, 32'd0);
        tick("dup_q2");
        ld(0, 0, 0);
        lanes(0, 0, 0, 0, 0, 0);
        chk("dup_busy_queued", 80'(bus.ld_busy_o), 80'(32'h4000));
        push_exp(0, 0, 0, 1, 14, 32'hA2);
        tick("dup_drain");
        chk("dup_busy_out", 80'(bus.ld_busy_o), 80'(32'h4000));
        push_exp(0, 0, 0, 0, 0, 0);
        tick("dup_idle");
        chk("dup_busy_clear", 80'(bus.ld_busy_o), 80'(0));

        // three loads queued, then reset discards them
        for (int c = 0; c < 3; c++) begin
            lanes(1, 20, 32'(c), 1, 21, 32'(c));
            ld(1, 5'(11 + c), 32'(32'h200 + c));
            push_exp(1, 20, 32'(c), 1, 21, 32'(c));
            tick($sformatf("rq_lanes%0d", c));
        end
        chk("rq_count", 80'(bus.ld_count_o), 80'(3));
        chk("rq_busy", 80'(bus.ld_busy_o), 80'(32'h3800));
        lanes(0, 0, 0, 0, 0, 0);
        ld(0, 0, 0);
        reset_i = 1'b1;
        #1;
        chk("rq_ready_in_reset", 80'(bus.ld_ready_o), 80'(0));
        push_exp(0, 0, 0, 0, 0, 0);
        tick("rq_reset");
        chk("rq_count_reset", 80'(bus.ld_count_o), 80'(0));
        chk("rq_busy_reset", 80'(bus.ld_busy_o), 80'(0));
        reset_i = 1'b0;
        #1;
        chk("rq_ready_after", 80'(bus.ld_ready_o), 80'(1));
        push_exp(0, 0, 0, 0, 0, 0);
        tick("rq_no_writes");

        // load to x0 is accepted and dropped
        ld(1, 0, 32'h1234);
        chk("x0_ready", 80'(bus.ld_ready_o), 80'(1));
        push_exp(0, 0, 0, 0, 0, 0);
        tick("x0_load");
        ld(0, 0, 0);
        chk("x0_busy", 80'(bus.ld_busy_o), 80'(0));
        chk("x0_count", 80'(bus.ld_count_o), 80'(0));
        push_exp(0, 0, 0, 0, 0, 0);
        tick("x0_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
